// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encodings and
// legal operand widths.
package serial_arith_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_RUN  = 2'b01;
  localparam state_t ST_DONE = 2'b10;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/serial_adder_if.sv
// Operand and result handshakes of the serial adder.
// Both channels use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both 1; the producer holds its data stable until then.
interface serial_adder_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
  );

endinterface

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders; the only arithmetic cell
// used by the serial adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic carry
);
  logic s1, c1, c2;

  half_adder u_ha0 (.a(a),  .b(b),    .sum(s1),  .carry(c1));
  half_adder u_ha1 (.a(s1), .b(c_in), .sum(sum), .carry(c2));

  assign carry = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds a + b + c_in LSB first, one bit per clock, through a
// single full adder and a carry flip-flop.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  serial_adder_if.slave bus,
  output state_t fsm_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c_in (carry),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.c_in;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
          carry  <= fa_carry;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (cnt == CNT_LAST) state <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.sum       = sum_sh;
  assign bus.c_out     = carry;
  assign fsm_state     = state;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=5.
module tb_serial_adder;
  import serial_arith_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(5)) if5 ();
  state_t st8, st5;

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave), .fsm_state(st8));
  serial_adder #(.WIDTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave), .fsm_state(st5));

  int n_checks = 0;
  int n_pass = 0;
  logic [8:0] exp_q[$];
  logic [5:0] exp5_q[$];

  // ---------------- driver tasks ----------------
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    int guard = 0;
    @(negedge clk);
    if8.a = a; if8.b = b; if8.c_in = ci; if8.in_valid = 1'b1;
    while (!if8.in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!if8.out_valid && lat < 40);
  endtask

  task automatic ack8();
    @(negedge clk); if8.out_ready = 1'b1;
    @(posedge clk); #1; if8.out_ready = 1'b0;
  endtask

  task automatic start5(input logic [4:0] a, input logic [4:0] b, input logic ci);
    int guard = 0;
    @(negedge clk);
    if5.a = a; if5.b = b; if5.c_in = ci; if5.in_valid = 1'b1;
    while (!if5.in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    if5.in_valid = 1'b0;
  endtask

  task automatic wait5(output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!if5.out_valid && lat < 40);
  endtask

  task automatic ack5();
    @(negedge clk); if5.out_ready = 1'b1;
    @(posedge clk); #1; if5.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_checks++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0) $display("FAIL reset_hs8 in_ready=%b out_valid=%b want 1/0", if8.in_ready, if8.out_valid); else n_pass++;
    n_checks++; if (if8.sum !== 8'h00 || if8.c_out !== 1'b0) $display("FAIL reset_out8 sum=%h c_out=%b want 00/0", if8.sum, if8.c_out); else n_pass++;
    n_checks++; if (st8 !== ST_IDLE || st5 !== ST_IDLE) $display("FAIL reset_state st8=%b st5=%b want 00", st8, st5); else n_pass++;
    n_checks++; if (if5.in_ready !== 1'b1 || if5.out_valid !== 1'b0 || if5.sum !== 5'h00) $display("FAIL reset_5 in_ready=%b out_valid=%b sum=%h want 1/0/00", if5.in_ready, if5.out_valid, if5.sum); else n_pass++;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    start8(8'h35, 8'h4A, 1'b0);
    wait8(lat);
    n_checks++; if (lat !== 8) $display("FAIL basic_latency got %0d want 8", lat); else n_pass++;
    n_checks++; if (if8.sum !== 8'h7F || if8.c_out !== 1'b0) $display("FAIL basic_sum got %h/%b want 7f/0", if8.sum, if8.c_out); else n_pass++;
    ack8();
    n_checks++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0) $display("FAIL basic_return_idle in_ready=%b out_valid=%b want 1/0", if8.in_ready, if8.out_valid); else n_pass++;
  endtask

  task automatic test_wrap();
    int lat;
    start8(8'hFF, 8'h01, 1'b0); wait8(lat);
    n_checks++; if (if8.sum !== 8'h00 || if8.c_out !== 1'b1) $display("FAIL wrap1 got %h/%b want 00/1", if8.sum, if8.c_out); else n_pass++;
    ack8();
    start8(8'hFF, 8'hFF, 1'b1); wait8(lat);
    n_checks++; if (if8.sum !== 8'hFF || if8.c_out !== 1'b1) $display("FAIL wrap2 got %h/%b want ff/1", if8.sum, if8.c_out); else n_pass++;
    ack8();
  endtask

  task automatic test_backpressure();
    int lat;
    start8(8'h12, 8'h34, 1'b0); wait8(lat);
    @(negedge clk);
    if8.a = 8'hA0; if8.b = 8'h70; if8.c_in = 1'b1; if8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (if8.out_valid !== 1'b1 || if8.in_ready !== 1'b0 || if8.sum !== 8'h46 || if8.c_out !== 1'b0)
        $display("FAIL bp_hold cyc%0d out_valid=%b in_ready=%b sum=%h c_out=%b want 1/0/46/0", i, if8.out_valid, if8.in_ready, if8.sum, if8.c_out);
      else n_pass++;
    end
    @(negedge clk); if8.out_ready = 1'b1;
    @(posedge clk); #1; if8.out_ready = 1'b0;
    n_checks++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0) $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", if8.in_ready, if8.out_valid); else n_pass++;
    @(posedge clk); #1; if8.in_valid = 1'b0;
    n_checks++; if (if8.in_ready !== 1'b0) $display("FAIL bp_accept in_ready=%b want 0", if8.in_ready); else n_pass++;
    wait8(lat);
    n_checks++; if (lat !== 8 || if8.sum !== 8'h11 || if8.c_out !== 1'b1) $display("FAIL bp_second lat=%0d sum=%h c_out=%b want 8/11/1", lat, if8.sum, if8.c_out); else n_pass++;
    ack8();
  endtask

  task automatic test_input_stability();
    logic [7:0] a, b; logic ci; logic [8:0] exp;
    for (int k = 0; k < 4; k++) begin
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
      exp = 9'(a) + 9'(b) + 9'(ci);
      start8(a, b, ci);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if8.a = 8'($urandom); if8.b = 8'($urandom); if8.c_in = 1'($urandom);
        @(posedge clk); #1;
      end
      n_checks++; if (if8.out_valid !== 1'b1 || {if8.c_out, if8.sum} !== exp) $display("FAIL stability op%0d out_valid=%b got %h want %h", k, if8.out_valid, {if8.c_out, if8.sum}, exp); else n_pass++;
      ack8();
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    start8(8'h5A, 8'h3C, 1'b1);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0 || if8.sum !== 8'h00 || if8.c_out !== 1'b0 || st8 !== ST_IDLE)
      $display("FAIL midreset_async in_ready=%b out_valid=%b sum=%h c_out=%b st=%b want 1/0/00/0/00", if8.in_ready, if8.out_valid, if8.sum, if8.c_out, st8);
    else n_pass++;
    @(negedge clk); @(posedge clk); #1;
    n_checks++; if (if8.out_valid !== 1'b0 || if8.sum !== 8'h00) $display("FAIL midreset_hold out_valid=%b sum=%h want 0/00", if8.out_valid, if8.sum); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    start8(8'h80, 8'h80, 1'b0); wait8(lat);
    n_checks++; if (lat !== 8 || if8.sum !== 8'h00 || if8.c_out !== 1'b1) $display("FAIL midreset_after lat=%0d sum=%h c_out=%b want 8/00/1", lat, if8.sum, if8.c_out); else n_pass++;
    ack8();
  endtask

  task automatic test_width5();
    int lat;
    start5(5'h13, 5'h0E, 1'b1); wait5(lat);
    n_checks++; if (lat !== 5) $display("FAIL w5_latency got %0d want 5", lat); else n_pass++;
    n_checks++; if (if5.sum !== 5'h02 || if5.c_out !== 1'b1) $display("FAIL w5_sum got %h/%b want 02/1", if5.sum, if5.c_out); else n_pass++;
    ack5();
    n_checks++; if (if5.in_ready !== 1'b1) $display("FAIL w5_return_idle in_ready=%b want 1", if5.in_ready); else n_pass++;
  endtask

  task automatic test_random5(input int n_ops);
    logic [4:0] a, b; logic ci; logic [5:0] exp; int lat; int errs;
    errs = 0;
    for (int i = 0; i < n_ops; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = 5'($urandom); b = 5'($urandom); ci = 1'($urandom);
      exp5_q.push_back(6'(a) + 6'(b) + 6'(ci));
      start5(a, b, ci);
      wait5(lat);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      exp = exp5_q.pop_front();
      n_checks++; if (lat !== 5) begin $display("FAIL rnd5_latency op%0d got %0d want 5", i, lat); errs++; end else n_pass++;
      n_checks++; if (if5.out_valid !== 1'b1 || {if5.c_out, if5.sum} !== exp) begin
        $display("FAIL rnd5_result op%0d a=%h b=%h ci=%b got %h want %h", i, a, b, ci, {if5.c_out, if5.sum}, exp); errs++;
      end else n_pass++;
      ack5();
      if (errs > 10) break;
    end
  endtask

  task automatic test_random8(input int n_ops);
    logic [7:0] a, b; logic ci; logic [8:0] exp; int lat;
    for (int i = 0; i < n_ops; i++) begin
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
      exp_q.push_back(9'(a) + 9'(b) + 9'(ci));
      start8(a, b, ci);
      wait8(lat);
      exp = exp_q.pop_front();
      n_checks++; if (lat !== 8 || {if8.c_out, if8.sum} !== exp) $display("FAIL rnd8 op%0d lat=%0d got %h want %h", i, lat, {if8.c_out, if8.sum}, exp); else n_pass++;
      ack8();
    end
  endtask

  initial begin
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.c_in = 1'b0; if8.out_ready = 1'b0;
    if5.in_valid = 1'b0; if5.a = '0; if5.b = '0; if5.c_in = 1'b0; if5.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_input_stability();
    test_reset_mid_op();
    test_width5();
    test_random5(1000);
    test_random8(200);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
